ifu_fetch_stage: RTL and testbench
==================================

# ifu_fetch_stage

Instruction-fetch stage of the single-cycle/pipelined RISC-V core. Owns the program counter, drives the word address of the combinational instruction ROM, and registers the returned instruction plus its PC into an IF/ID output slot with a valid/ready handshake to decode. Sits directly upstream of the ROM, consuming its data, and accepts branch/jump redirects from execute and halt/resume control from the ecall logic.

## Interface
- `ADDR_W`, 10: ROM word-address width; fetch window is 2^ADDR_W words.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  ADDR_W  word address to ROM, always `pc[ADDR_W+1:2]`.
- `rom_data`  in  32  instruction from ROM, combinational, valid same cycle.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  redirect target byte address.
- `halt_req`  in  1  stop fetching (ecall exit, a7=10).
- `resume`  in  1  restart fetching from the current PC.
- `if_valid`  out  1  output slot holds an instruction.
- `if_ready`  in  1  decode accepts the slot this cycle.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  32  byte PC of `if_instr`.
- `halted`  out  1  FSM in HALT.
- `fetch_cnt`  out  32  instructions handed to decode (see Configuration).
- `stall_cnt`  out  32  cycles with `if_valid & ~if_ready` (see Configuration).

## Operation
- FSM states: RUN, HALT. Reset → RUN.
- Slot load condition in RUN: `load = ~if_valid | if_ready`. On load: `if_instr<=rom_data`, `if_pc<=pc`, `if_valid<=1`, `pc<=pc+4`.
- Backpressure (`if_valid & ~if_ready`): slot, `pc`, `rom_addr` all hold.
- Redirect (any state): `pc <= {redirect_pc[31:2],2'b00}`; slot flushed (`if_valid<=0`), takes priority over load and over handshake completion. The flushed instruction is not counted as fetched.
- `halt_req` in RUN: → HALT; no new loads. A slot already valid stays valid until accepted, then `if_valid<=0`. The PC is left pointing at the next unfetched instruction.
- HALT: `resume` → RUN; the first load occurs on the following edge. Redirect in HALT updates `pc` and stays in HALT.
- Simultaneous `halt_req` + `redirect_valid`: both apply, giving HALT with the new PC and an empty slot. Simultaneous `halt_req` + `resume`: `halt_req` wins.
- PC arithmetic: 32-bit, wraps modulo 2^32. `rom_addr` wraps at 2^ADDR_W words; out-of-range PCs alias silently.
- Reset values: `pc=RESET_PC`, `if_valid=0`, `if_instr=32'h0000_0013` (NOP), `if_pc=0`, `halted=0`, counters 0. An assertion of `rst_n` mid-stall or mid-redirect discards all state immediately.

## Timing
- `rom_addr` is a combinational function of the `pc` register. ROM data is captured on the same edge that advances `pc`.
- First valid instruction appears one edge after `rst_n` deasserts.
- Sustained throughput: 1 instruction/cycle with `if_ready=1`.
- Redirect penalty: asserted before edge N gives `if_valid=0` after N; the target instruction is valid after N+1.
- `halted` asserts the cycle after the `halt_req` edge and deasserts the cycle after the `resume` edge.
- No combinational path from `if_ready`, `redirect_*`, `halt_req`, or `resume` to any output.

## Configuration
- `IFU_PERF_CNT_EN` defined: `fetch_cnt` increments on each `if_valid & if_ready` and `stall_cnt` on each `if_valid & ~if_ready`. Both wrap at 2^32 and reset to 0.
- Not defined: both outputs are tied to 32'h0 and no counter flops are synthesised.

## Structure
- Shared package `ifu_pkg`: FSM state encoding (RUN, HALT), `NOP_INSTR = 32'h0000_0013`, `PC_STEP = 4`.
- One sub-module, `ifu_perf_cnt`, holds the two counters. It is instantiated only under `IFU_PERF_CNT_EN`.

## Test plan
- Reset release, `if_ready=1`, ROM word0=0x00100093 and word1=0x0100006F: edge 1 gives `if_pc=0`/`if_instr=0x00100093`; edge 2 gives `if_pc=4`/`0x0100006F`.
- `if_ready=0` for 3 cycles while valid: `if_instr`, `if_pc`, and `rom_addr` are unchanged. Then `if_ready=1` yields the next PC on the following edge, and `stall_cnt` increments by 3.
- `redirect_valid=1`, `redirect_pc=0x4A` while the slot is valid: `if_valid=0` for one cycle, then `if_pc=0x48` with `if_instr=ROM[18]`. The flushed slot is not added to `fetch_cnt`.
- `halt_req` with `if_ready=0`: `halted=1` and the slot is held. After `if_ready=1`, `if_valid=0` and `rom_addr` is frozen. `resume` continues at the next sequential PC with no skipped instruction.
- `halt_req` and `redirect_valid` (target 0x100) on the same edge: HALT with `if_valid=0`. After `resume`, the first `if_pc=0x100`.
- Assert `rst_n=0` asynchronously mid-stream: all outputs return to reset values before the next edge, and `pc` restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   ifu_state_e : fetch FSM encoding (RUN fetches, HALT freezes the PC).
//   NOP_INSTR   : value shown in the IF/ID slot out of reset (addi x0,x0,0).
//   PC_STEP     : byte increment between sequential instructions.
package ifu_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } ifu_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch-stage performance counters, built only when IFU_PERF_CNT_EN is defined.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   fire       : an instruction was handed to decode this cycle
//   stall      : the slot was valid but decode did not accept it this cycle
//   fetch_cnt  : running count of fire cycles (wraps at 2^32)
//   stall_cnt  : running count of stall cycles (wraps at 2^32)
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fire,
    input  logic        stall,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    logic [31:0] fetch_cnt_r;
    logic [31:0] stall_cnt_r;

    // Free-running event counters; natural 32-bit overflow gives the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (fire) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
            if (stall) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a combinational instruction
// ROM and registers the returned word plus its PC into a valid/ready IF/ID slot.
// Branch/jump redirects flush the slot; halt_req/resume stop and restart fetch.
// Optional build macro: IFU_PERF_CNT_EN adds fetch/stall counters; without it
// fetch_cnt and stall_cnt read as zero.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rom_addr / rom_data         : ROM word address (pc[ADDR_W+1:2]) / instruction
//   redirect_valid, redirect_pc : taken branch/jump and its byte target
//   halt_req, resume            : stop fetching / restart from the current PC
//   if_valid, if_ready          : IF/ID slot handshake
//   if_instr, if_pc             : slot contents
//   halted                      : FSM is in HALT
//   fetch_cnt, stall_cnt        : performance counters
module ifu_fetch_stage
    import ifu_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt_req,
    input  logic              resume,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic              halted,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
);

    ifu_state_e  state_r;
    logic [31:0] pc_r;
    logic        if_valid_r;
    logic [31:0] if_instr_r;
    logic [31:0] if_pc_r;

    logic        accept_s;
    logic        load_s;
    logic        unused_s;

    // The low target bits are dropped when forming the word-aligned redirect PC.
    assign unused_s = ^redirect_pc[1:0];

    // Slot handshake and load qualification. A redirect overrides both.
    always_comb begin
        accept_s = if_valid_r & if_ready;
        load_s   = 1'b0;
        if ((state_r == ST_RUN) && !halt_req && !redirect_valid) begin
            load_s = ~if_valid_r | if_ready;
        end else begin
            load_s = 1'b0;
        end
    end

    // Fetch FSM with PC and IF/ID slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            if_valid_r <= 1'b0;
            if_instr_r <= NOP_INSTR;
            if_pc_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_req) begin
                        state_r <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // halt_req wins over a simultaneous resume.
                    if (resume && !halt_req) begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase

            if (redirect_valid) begin
                pc_r       <= {redirect_pc[31:2], 2'b00};
                if_valid_r <= 1'b0;
            end else if (load_s) begin
                if_instr_r <= rom_data;
                if_pc_r    <= pc_r;
                if_valid_r <= 1'b1;
                pc_r       <= pc_r + PC_STEP;
            end else if (accept_s) begin
                // Accepted while halting/halted: drain without refilling.
                if_valid_r <= 1'b0;
            end
        end
    end

    assign rom_addr = pc_r[ADDR_W+1:2];
    assign if_valid = if_valid_r;
    assign if_instr = if_instr_r;
    assign if_pc    = if_pc_r;
    assign halted   = (state_r == ST_HALT);

`ifdef IFU_PERF_CNT_EN
    logic fire_s;
    logic stall_s;

    // A flushed slot is not counted as delivered, even if decode was ready.
    assign fire_s  = accept_s & ~redirect_valid;
    assign stall_s = if_valid_r & ~if_ready;

    ifu_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .fire      (fire_s),
        .stall     (stall_s),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );
`else
    assign fetch_cnt = 32'h0000_0000;
    assign stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Self-checking bench for ifu_fetch_stage: directed scenarios with literal
// expectations followed by randomized control traffic checked every cycle
// against a behavioural model of the fetch rules.
module tb_ifu_fetch_stage;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halt_req;
    logic              resume;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              halted;
    logic [31:0]       fetch_cnt;
    logic [31:0]       stall_cnt;

    logic [31:0] rom [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_i;
    logic [31:0] m_ipc;
    logic        m_halt;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    ifu_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume         (resume),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one step of the fetch rules per rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc   <= 32'h0000_0000;
            m_v    <= 1'b0;
            m_i    <= 32'h0000_0013;
            m_ipc  <= 32'h0000_0000;
            m_halt <= 1'b0;
            m_fc   <= 32'd0;
            m_sc   <= 32'd0;
        end else begin
            if (redirect_valid) begin
                m_pc <= {redirect_pc[31:2], 2'b00};
                m_v  <= 1'b0;
            end else if (!m_halt && !halt_req && (!m_v || if_ready)) begin
                m_v   <= 1'b1;
                m_i   <= rom[m_pc[ADDR_W+1:2]];
                m_ipc <= m_pc;
                m_pc  <= m_pc + 32'd4;
            end else if (m_v && if_ready) begin
                m_v <= 1'b0;
            end
            if (!m_halt && halt_req)
                m_halt <= 1'b1;
            else if (m_halt && resume && !halt_req)
                m_halt <= 1'b0;
            if (m_v && if_ready && !redirect_valid) m_fc <= m_fc + 32'd1;
            if (m_v && !if_ready) m_sc <= m_sc + 32'd1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_valid", {31'd0, if_valid}, {31'd0, m_v});
            chk("cyc_halted", {31'd0, halted}, {31'd0, m_halt});
            chk("cyc_rom_addr", {22'd0, rom_addr}, {22'd0, m_pc[ADDR_W+1:2]});
            chk("cyc_instr", if_instr, m_i);
            chk("cyc_pc", if_pc, m_ipc);
`ifdef IFU_PERF_CNT_EN
            chk("cyc_fetch_cnt", fetch_cnt, m_fc);
            chk("cyc_stall_cnt", stall_cnt, m_sc);
`else
            chk("cyc_fetch_cnt", fetch_cnt, 32'd0);
            chk("cyc_stall_cnt", stall_cnt, 32'd0);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s0;
        logic [31:0] f0;
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = $urandom;
        rom[0]  = 32'h0010_0093;
        rom[1]  = 32'h0100_006F;
        rom[18] = 32'hCAFE_0013;
        rom[19] = 32'h0042_8293;

        rst_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'd0; halt_req = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0000_0013);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // First two sequential fetches
        @(negedge clk);
        chk("e1_pc", if_pc, 32'd0);
        chk("e1_instr", if_instr, 32'h0010_0093);
        @(negedge clk);
        chk("e2_pc", if_pc, 32'd4);
        chk("e2_instr", if_instr, 32'h0100_006F);

        // Three cycles of backpressure
        s0 = stall_cnt;
        if_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_pc", if_pc, 32'd4);
            chk("stall_instr", if_instr, 32'h0100_006F);
            chk("stall_rom_addr", {22'd0, rom_addr}, 32'd2);
        end
        if_ready = 1'b1;
        @(negedge clk);
        chk("post_stall_pc", if_pc, 32'd8);
`ifdef IFU_PERF_CNT_EN
        chk("stall_delta", stall_cnt - s0, 32'd3);
`else
        chk("stall_delta", stall_cnt, 32'd0);
`endif

        // Redirect to 0x4A while slot valid
        f0 = fetch_cnt;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_004A;
        @(negedge clk);
        chk("redir_flush", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_pc", if_pc, 32'h0000_0048);
        chk("redir_instr", if_instr, 32'hCAFE_0013);
`ifdef IFU_PERF_CNT_EN
        chk("redir_fetch_delta", fetch_cnt - f0, 32'd0);
`else
        chk("redir_fetch_delta", fetch_cnt, 32'd0);
`endif

        // Halt under backpressure
        if_ready = 1'b0; halt_req = 1'b1;
        @(negedge clk);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_held_valid", {31'd0, if_valid}, 32'd1);
        chk("halt_held_pc", if_pc, 32'h0000_0048);
        halt_req = 1'b0; if_ready = 1'b1;
        @(negedge clk);
        chk("halt_drain", {31'd0, if_valid}, 32'd0);
        chk("halt_rom_addr", {22'd0, rom_addr}, 32'd19);
        @(negedge clk);
        chk("halt_rom_addr2", {22'd0, rom_addr}, 32'd19);
        resume = 1'b1;
        @(negedge clk);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_no_load", {31'd0, if_valid}, 32'd0);
        resume = 1'b0;
        @(negedge clk);
        chk("resume_pc", if_pc, 32'h0000_004C);
        chk("resume_instr", if_instr, 32'h0042_8293);

        // Halt and redirect together
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk);
        chk("hr_halted", {31'd0, halted}, 32'd1);
        chk("hr_valid", {31'd0, if_valid}, 32'd0);
        chk("hr_rom_addr", {22'd0, rom_addr}, 32'h0000_0040);
        halt_req = 1'b0; redirect_valid = 1'b0; resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        @(negedge clk);
        chk("hr_resume_pc", if_pc, 32'h0000_0100);
        chk("hr_resume_valid", {31'd0, if_valid}, 32'd1);

        // Randomized control traffic
        repeat (2000) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            halt_req       = ($urandom_range(0, 19) == 0);
            resume         = redirect_valid ? 1'b0 : ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        if_ready = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_instr", if_instr, 32'h0000_0013);
        chk("arst_pc", if_pc, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_rom_addr", {22'd0, rom_addr}, 32'd0);
        chk("arst_fetch_cnt", fetch_cnt, 32'd0);
        chk("arst_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_restart_pc", if_pc, 32'd0);
        chk("arst_restart_instr", if_instr, 32'h0010_0093);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
